mux4_rr: RTL and testbench



---
 rtl/mux_pkg.sv | 29 ++
 rtl/rr_arbiter4.sv | 28 ++
 rtl/mux4_rr.sv | 84 ++++++++
 tb/tb_mux4_rr.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared types and the round-robin pick function for the 4:1 packet mux.
// Purely combinational helpers; no state lives here.
package mux_pkg;

    localparam int CH_N  = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } mux_state_t;

    // Returns {found, idx}: first set bit of valid searching from ptr upward, wrapping.
    function automatic logic [SEL_W:0] rr_pick(input logic [CH_N-1:0] valid,
                                               input logic [SEL_W-1:0] ptr);
        logic [SEL_W:0]   res;
        logic [SEL_W-1:0] idx;
        res = '0;
        // Walk from the farthest offset down so the nearest valid channel wins.
        for (int i = CH_N - 1; i >= 0; i--) begin
            idx = ptr + SEL_W'(i);
            if (valid[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Round-robin pick over four requests plus the rotating priority pointer.
// Grant is combinational; the pointer moves to grant+1 only when advance is strobed.
module rr_arbiter4
    import mux_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CH_N-1:0]  req,
    input  logic             advance,
    output logic             found,
    output logic [SEL_W-1:0] grant
);

    logic [SEL_W-1:0] ptr;

    always_comb begin
        {found, grant} = rr_pick(req, ptr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= grant + SEL_W'(1);
        end
    end

endmodule

// File: rtl/mux4_rr.sv
// Merges four valid/ready packet streams into one, tagging beats with source index; 1-cycle latency.
// Arbitrates round-robin per packet; in_ready is zero-cycle back-pressure from the output register.
module mux4_rr
    import mux_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CH_N-1:0]   in_valid,
    input  logic [CH_N*DW-1:0] in_data,
    input  logic [CH_N-1:0]   in_last,
    output logic [CH_N-1:0]   in_ready,
    output logic              out_valid,
    output logic [DW-1:0]     out_data,
    output logic              out_last,
    output logic [SEL_W-1:0]  out_sel,
    input  logic              out_ready
);

    mux_state_t       state;
    logic [SEL_W-1:0] owner;
    logic [SEL_W-1:0] arb_grant;
    logic [SEL_W-1:0] sel;
    logic             arb_found;
    logic             load_en;
    logic             eligible;
    logic             xfer;
    logic             advance;
    logic [DW-1:0]    beat_data;
    logic             beat_last;

    rr_arbiter4 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (in_valid),
        .advance (advance),
        .found   (arb_found),
        .grant   (arb_grant)
    );

    always_comb begin
        load_en = !out_valid || out_ready;
        sel     = arb_grant;
        eligible = arb_found;
        if (state == LOCK) begin
            sel      = owner;
            eligible = in_valid[owner];
        end
        // rst_n gating keeps in_ready quiet while reset is held.
        xfer      = eligible && load_en && rst_n;
        advance   = xfer && (state == IDLE);
        in_ready  = xfer ? (CH_N'(1) << sel) : '0;
        beat_data = in_data[sel*DW +: DW];
        beat_last = in_last[sel];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_sel   <= '0;
        end else begin
            if (load_en) begin
                out_valid <= xfer;
            end
            if (xfer) begin
                out_data <= beat_data;
                out_last <= beat_last;
                out_sel  <= sel;
                if (state == IDLE && !beat_last) begin
                    state <= LOCK;
                    owner <= sel;
                end else if (state == LOCK && beat_last) begin
                    state <= IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_mux4_rr.sv
// Directed checks of reset, fairness, packet lock, stall and pointer wrap for mux4_rr,
// followed by a randomized per-channel ordering scoreboard.
module tb_mux4_rr;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    in_valid;
    logic [4*DW-1:0] in_data;
    logic [3:0]    in_last;
    logic [3:0]    in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic [1:0]    out_sel;
    logic          out_ready;

    int n_checks = 0;
    int n_errors = 0;

    logic [8:0] fifo [4][16];
    int         wr [4];
    int         rd [4];
    logic [7:0] pend_d [4];
    logic       pend_l [4];
    logic [5:0] seq [4];
    logic       locked;
    logic [1:0] lock_ch;

    mux4_rr #(.DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [7:0] d,
                           input logic l, input logic [1:0] s);
        chk({tag, "_valid"}, out_valid, v);
        chk({tag, "_data"},  out_data,  d);
        chk({tag, "_last"},  out_last,  l);
        chk({tag, "_sel"},   out_sel,   s);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int c, input logic v, input logic [7:0] d, input logic l);
        in_valid[c]          = v;
        in_data[c*DW +: DW]  = d;
        in_last[c]           = l;
    endtask

    task automatic gen(input int c);
        logic [1:0] cc;
        cc        = 2'(c);
        pend_d[c] = {cc, seq[c]};
        pend_l[c] = ($urandom_range(0, 2) == 0);
        seq[c]    = seq[c] + 6'd1;
    endtask

    task automatic pop_check();
        int s;
        s = int'(out_sel);
        chk("rnd_have", 32'(wr[s] != rd[s]), 1);
        if (wr[s] != rd[s]) begin
            chk("rnd_beat", {out_last, out_data}, fifo[s][rd[s] % 16]);
            rd[s]++;
        end
        if (locked) begin
            chk("rnd_nointlv", out_sel, lock_ch);
        end
        locked  = !out_last;
        lock_ch = out_sel;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        in_last   = '0;
        out_ready = 1'b0;
        repeat (2) step();

        // Reset state with traffic offered.
        for (int c = 0; c < 4; c++) set_ch(c, 1'b1, 8'hA0 + 8'(c), 1'b1);
        out_ready = 1'b1;
        #1;
        chk("rst_ready", in_ready, 0);
        chk_out("rst", 1'b0, 8'h00, 1'b0, 2'd0);
        rst_n = 1'b1;
        #1;

        // Fairness: single-beat packets on all channels.
        for (int k = 0; k < 5; k++) begin
            chk("fair_ready", in_ready, 32'(4'b0001 << (k % 4)));
            step();
            chk_out("fair", 1'b1, 8'hA0 + 8'(k % 4), 1'b1, 2'(k % 4));
        end

        // Asynchronous reset mid-traffic, then first grant is channel 0 again.
        rst_n = 1'b0;
        #1;
        chk_out("arst", 1'b0, 8'h00, 1'b0, 2'd0);
        chk("arst_ready", in_ready, 0);
        step();
        rst_n = 1'b1;
        #1;
        chk("arst_grant", in_ready, 4'b0001);
        step();
        chk_out("arst_first", 1'b1, 8'hA0, 1'b1, 2'd0);

        // Packet lock on ch1 with ch2 contending, including a valid gap.
        set_ch(0, 1'b0, 8'h00, 1'b0);
        set_ch(3, 1'b0, 8'h00, 1'b0);
        set_ch(1, 1'b1, 8'd11, 1'b0);
        set_ch(2, 1'b1, 8'd21, 1'b1);
        #1;
        chk("lk_ready0", in_ready, 4'b0010);
        step();
        chk_out("lk_b0", 1'b1, 8'd11, 1'b0, 2'd1);
        set_ch(1, 1'b1, 8'd12, 1'b0);
        #1;
        chk("lk_ready1", in_ready, 4'b0010);
        step();
        chk_out("lk_b1", 1'b1, 8'd12, 1'b0, 2'd1);
        in_valid[1] = 1'b0;
        #1;
        chk("lk_gap_ready", in_ready, 4'b0000);
        step();
        chk("lk_gap_valid", out_valid, 0);
        chk("lk_gap_data", out_data, 8'd12);
        set_ch(1, 1'b1, 8'd13, 1'b1);
        #1;
        chk("lk_ready2", in_ready, 4'b0010);
        step();
        chk_out("lk_b2", 1'b1, 8'd13, 1'b1, 2'd1);
        set_ch(1, 1'b0, 8'h00, 1'b0);
        #1;
        chk("lk_next_ready", in_ready, 4'b0100);
        step();
        chk_out("lk_next", 1'b1, 8'd21, 1'b1, 2'd2);

        // Stall with a new beat waiting on ch2.
        set_ch(2, 1'b1, 8'd31, 1'b1);
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("stall_ready", in_ready, 0);
            chk_out("stall", 1'b1, 8'd21, 1'b1, 2'd2);
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("stall_rel_ready", in_ready, 4'b0100);
        step();
        chk_out("stall_rel", 1'b1, 8'd31, 1'b1, 2'd2);
        set_ch(2, 1'b0, 8'h00, 1'b0);
        #1;
        chk("drain_ready", in_ready, 0);
        step();
        chk("drain_valid", out_valid, 0);
        chk("drain_data", out_data, 8'd31);

        // Pointer wrap: ch3 then ch0, pointer ends at 1.
        set_ch(3, 1'b1, 8'h33, 1'b1);
        #1;
        chk("wrap_ready3", in_ready, 4'b1000);
        step();
        chk_out("wrap3", 1'b1, 8'h33, 1'b1, 2'd3);
        set_ch(3, 1'b0, 8'h00, 1'b0);
        set_ch(0, 1'b1, 8'h40, 1'b1);
        #1;
        chk("wrap_ready0", in_ready, 4'b0001);
        step();
        chk_out("wrap0", 1'b1, 8'h40, 1'b1, 2'd0);
        for (int c = 0; c < 4; c++) set_ch(c, 1'b1, 8'h50 + 8'(c), 1'b1);
        #1;
        chk("wrap_ptr", in_ready, 4'b0010);
        step();
        in_valid = '0;
        step();

        // Randomized traffic with per-channel ordering scoreboard.
        locked  = 1'b0;
        lock_ch = '0;
        for (int c = 0; c < 4; c++) begin
            wr[c]  = 0;
            rd[c]  = 0;
            seq[c] = '0;
            gen(c);
        end
        for (int cyc = 0; cyc < 10000; cyc++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            for (int c = 0; c < 4; c++) begin
                set_ch(c, ($urandom_range(0, 3) != 0), pend_d[c], pend_l[c]);
            end
            #1;
            chk("rnd_onehot", 32'($countones(in_ready) <= 1), 1);
            if (out_valid && out_ready) pop_check();
            for (int c = 0; c < 4; c++) begin
                if (in_valid[c] && in_ready[c]) begin
                    fifo[c][wr[c] % 16] = {pend_l[c], pend_d[c]};
                    wr[c]++;
                    gen(c);
                end
            end
            step();
        end
        in_valid  = '0;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            if (out_valid && out_ready) pop_check();
            step();
        end
        for (int c = 0; c < 4; c++) begin
            chk("rnd_all_out", wr[c] - rd[c], 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
